// File: rtl/ifid_pipe_buffer.sv
// IF/ID pipeline buffer: registers the fetched instruction and its PC_Next for decode.
// It inserts NOP bubbles on imem stall or flush, and holds its contents on a decode stall.
// Latency is one cycle. Optional bubble counter is enabled by defining IFID_BUBBLE_CNT_EN.
module ifid_pipe_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction_in,
  input  logic [15:0] PC_Next_in,
  input  logic        instructionMemoryStall_in,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic [15:0] instruction_out,
  output logic [15:0] PC_Next_out,
  output logic        valid_out,
  output logic [15:0] bubbleCount
);

  localparam logic [15:0] NOP_WORD = 16'h0800;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // Next-state and output selection; priority is flush > stall > drain/imem stall > load.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_in) begin
      // Squash: the word fetched alongside the flush is on the wrong path too.
      state_d = DRAIN;
      instr_d = NOP_WORD;
      pc_d    = PC_Next_in;
      valid_d = 1'b0;
    end else if (stall_in) begin
      // Hold everything; DRAIN keeps its pending squash across the stall.
      state_d = (state_q == DRAIN) ? DRAIN : HOLD;
    end else if (state_q == DRAIN || instructionMemoryStall_in) begin
      state_d = RUN;
      instr_d = NOP_WORD;
      pc_d    = PC_Next_in;
      valid_d = 1'b0;
    end else begin
      state_d = RUN;
      instr_d = instruction_in;
      pc_d    = PC_Next_in;
      valid_d = 1'b1;
    end
  end

  // Pipeline register with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      instr_q <= NOP_WORD;
      pc_q    <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instruction_out = instr_q;
  assign PC_Next_out     = pc_q;
  assign valid_out       = valid_q;

`ifdef IFID_BUBBLE_CNT_EN
  logic        bubble_edge;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Count every edge that loads a bubble, saturating at all-ones.
  always_comb begin
    bubble_edge  = flush_in |
                   (~stall_in & ((state_q == DRAIN) | instructionMemoryStall_in));
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_edge && bubble_cnt_q != 16'hFFFF) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // Bubble counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= 16'h0000;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubbleCount = bubble_cnt_q;
`else
  assign bubbleCount = 16'h0000;
`endif

endmodule

// File: tb/tb_ifid_pipe_buffer.sv
// Bench for ifid_pipe_buffer: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a squash-flag behavioural model.
module tb_ifid_pipe_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction_in;
  logic [15:0] PC_Next_in;
  logic        instructionMemoryStall_in;
  logic        stall_in;
  logic        flush_in;
  logic [15:0] instruction_out;
  logic [15:0] PC_Next_out;
  logic        valid_out;
  logic [15:0] bubbleCount;

  always #5 clk = ~clk;

  ifid_pipe_buffer dut (
    .clk                       (clk),
    .rst                       (rst),
    .instruction_in            (instruction_in),
    .PC_Next_in                (PC_Next_in),
    .instructionMemoryStall_in (instructionMemoryStall_in),
    .stall_in                  (stall_in),
    .flush_in                  (flush_in),
    .instruction_out           (instruction_out),
    .PC_Next_out               (PC_Next_out),
    .valid_out                 (valid_out),
    .bubbleCount               (bubbleCount)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: visible outputs, bubble tally, and "next unstalled edge is squashed".
  logic [15:0] m_instr = 16'h0800;
  logic [15:0] m_pc    = 16'h0000;
  logic        m_valid = 1'b0;
  int          m_bub   = 0;
  bit          m_squash = 1'b0;

  function automatic logic [15:0] exp_count(input int bub);
`ifdef IFID_BUBBLE_CNT_EN
    return 16'(bub);
`else
    return (bub < 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  task automatic model_bubble(input logic [15:0] pc);
    m_instr = 16'h0800;
    m_valid = 1'b0;
    m_pc    = pc;
    if (m_bub < 65535) m_bub++;
  endtask

  task automatic model_edge(input logic r, input logic [15:0] ins, input logic [15:0] pc,
                            input logic im, input logic st, input logic fl);
    if (r) begin
      m_instr = 16'h0800; m_pc = 16'h0000; m_valid = 1'b0; m_bub = 0; m_squash = 1'b0;
    end else if (fl) begin
      model_bubble(pc);
      m_squash = 1'b1;
    end else if (st) begin
      // outputs frozen
    end else if (m_squash || im) begin
      model_bubble(pc);
      m_squash = 1'b0;
    end else begin
      m_instr = ins; m_pc = pc; m_valid = 1'b1;
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one edge of inputs, advance the model, sample just after the edge.
  task automatic step(input logic r, input logic [15:0] ins, input logic [15:0] pc,
                      input logic im, input logic st, input logic fl);
    rst = r; instruction_in = ins; PC_Next_in = pc;
    instructionMemoryStall_in = im; stall_in = st; flush_in = fl;
    @(posedge clk);
    #1;
    model_edge(r, ins, pc, im, st, fl);
  endtask

  task automatic check_model(input string tag);
    check16({tag, ".instr"}, instruction_out, m_instr);
    check16({tag, ".pc"},    PC_Next_out,     m_pc);
    check16({tag, ".valid"}, {15'd0, valid_out}, {15'd0, m_valid});
    check16({tag, ".count"}, bubbleCount,     exp_count(m_bub));
  endtask

  typedef struct {
    logic        r;
    logic [15:0] ins;
    logic [15:0] pc;
    logic        im;
    logic        st;
    logic        fl;
    logic [15:0] e_ins;
    logic [15:0] e_pc;
    logic        e_v;
    int          e_bub;
  } vec_t;

  vec_t vecs[32];

  initial begin
    rst = 1'b1; instruction_in = '0; PC_Next_in = '0;
    instructionMemoryStall_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    #2;

    //            r  ins       pc        im st fl   e_ins     e_pc      v  bub
    vecs[0]  = '{1, 16'h0000, 16'h0000, 0, 0, 0, 16'h0800, 16'h0000, 0, 0};
    vecs[1]  = '{0, 16'h4321, 16'h0002, 0, 0, 0, 16'h4321, 16'h0002, 1, 0};
    vecs[2]  = '{0, 16'h1111, 16'h0004, 0, 0, 0, 16'h1111, 16'h0004, 1, 0};
    vecs[3]  = '{0, 16'h2222, 16'h0006, 0, 1, 0, 16'h1111, 16'h0004, 1, 0};
    vecs[4]  = '{0, 16'h2222, 16'h0006, 0, 1, 0, 16'h1111, 16'h0004, 1, 0};
    vecs[5]  = '{0, 16'h2222, 16'h0006, 0, 1, 0, 16'h1111, 16'h0004, 1, 0};
    vecs[6]  = '{0, 16'h2222, 16'h0006, 0, 0, 0, 16'h2222, 16'h0006, 1, 0};
    vecs[7]  = '{0, 16'hAAAA, 16'h0008, 0, 0, 1, 16'h0800, 16'h0008, 0, 1};
    vecs[8]  = '{0, 16'hBBBB, 16'h000A, 0, 0, 0, 16'h0800, 16'h000A, 0, 2};
    vecs[9]  = '{0, 16'hCCCC, 16'h000C, 0, 0, 0, 16'hCCCC, 16'h000C, 1, 2};
    vecs[10] = '{0, 16'hDEAD, 16'h000E, 1, 0, 0, 16'h0800, 16'h000E, 0, 3};
    vecs[11] = '{0, 16'hDEAD, 16'h000E, 1, 0, 0, 16'h0800, 16'h000E, 0, 4};
    vecs[12] = '{0, 16'hDEAD, 16'h000E, 1, 0, 0, 16'h0800, 16'h000E, 0, 5};
    vecs[13] = '{0, 16'hDEAD, 16'h000E, 1, 0, 0, 16'h0800, 16'h000E, 0, 6};
    vecs[14] = '{0, 16'h1234, 16'h0010, 0, 0, 0, 16'h1234, 16'h0010, 1, 6};
    vecs[15] = '{0, 16'h9999, 16'h0012, 0, 1, 1, 16'h0800, 16'h0012, 0, 7};
    vecs[16] = '{0, 16'h8888, 16'h0014, 0, 1, 0, 16'h0800, 16'h0012, 0, 7};
    vecs[17] = '{0, 16'h7777, 16'h0016, 0, 1, 0, 16'h0800, 16'h0012, 0, 7};
    vecs[18] = '{0, 16'h6666, 16'h0018, 0, 0, 0, 16'h0800, 16'h0018, 0, 8};
    vecs[19] = '{0, 16'h5A5A, 16'h001A, 0, 0, 0, 16'h5A5A, 16'h001A, 1, 8};
    vecs[20] = '{0, 16'h1010, 16'h001C, 0, 0, 1, 16'h0800, 16'h001C, 0, 9};
    vecs[21] = '{1, 16'h5555, 16'h0020, 0, 0, 0, 16'h0800, 16'h0000, 0, 0};
    vecs[22] = '{0, 16'h5555, 16'h0022, 0, 0, 0, 16'h5555, 16'h0022, 1, 0};
    vecs[23] = '{0, 16'h3333, 16'h0024, 1, 1, 0, 16'h5555, 16'h0022, 1, 0};
    vecs[24] = '{0, 16'h3333, 16'h0026, 1, 0, 0, 16'h0800, 16'h0026, 0, 1};
    vecs[25] = '{0, 16'h3434, 16'h0028, 0, 0, 1, 16'h0800, 16'h0028, 0, 2};
    vecs[26] = '{0, 16'h3535, 16'h002A, 0, 0, 1, 16'h0800, 16'h002A, 0, 3};
    vecs[27] = '{0, 16'h3636, 16'h002C, 1, 0, 0, 16'h0800, 16'h002C, 0, 4};
    vecs[28] = '{0, 16'h3737, 16'h002E, 0, 1, 0, 16'h0800, 16'h002C, 0, 4};
    vecs[29] = '{0, 16'h4444, 16'h0030, 0, 1, 1, 16'h0800, 16'h0030, 0, 5};
    vecs[30] = '{0, 16'h4545, 16'h0032, 0, 0, 0, 16'h0800, 16'h0032, 0, 6};
    vecs[31] = '{0, 16'h4646, 16'h0034, 0, 0, 0, 16'h4646, 16'h0034, 1, 6};

    for (int i = 0; i < 32; i++) begin
      step(vecs[i].r, vecs[i].ins, vecs[i].pc, vecs[i].im, vecs[i].st, vecs[i].fl);
      check16($sformatf("vec%0d.instr", i), instruction_out, vecs[i].e_ins);
      check16($sformatf("vec%0d.pc", i), PC_Next_out, vecs[i].e_pc);
      check16($sformatf("vec%0d.valid", i), {15'd0, valid_out}, {15'd0, vecs[i].e_v});
      check16($sformatf("vec%0d.count", i), bubbleCount, exp_count(vecs[i].e_bub));
    end

    // Long stall: outputs must stay frozen while the inputs churn.
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0);
      check_model($sformatf("longhold%0d", i));
    end

    // Reset asserted in the middle of a hold and of a drain, with other inputs active.
    step(1'b0, 16'h7A7A, 16'h0100, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h7B7B, 16'h0102, 1'b1, 1'b1, 1'b1);
    check_model("rst_in_hold");
    step(1'b0, 16'h7C7C, 16'h0104, 1'b0, 1'b0, 1'b0);
    check_model("after_rst_hold");
    step(1'b0, 16'h7D7D, 16'h0106, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h7E7E, 16'h0108, 1'b0, 1'b1, 1'b1);
    check_model("rst_in_drain");

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 49) == 0), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0));
      check_model($sformatf("rand%0d", i));
    end

`ifdef IFID_BUBBLE_CNT_EN
    // Drive the counter to saturation and confirm it sticks at all-ones.
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) begin
      step(1'b0, 16'h0000, 16'(i), 1'b1, 1'b0, 1'b0);
    end
    check_model("saturate");
    check16("saturate.abs", bubbleCount, 16'hFFFF);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    check_model("saturate_flush");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
